des_decrypt_iter: RTL and testbench

//  Iterative DES decryption core (FIPS 46-3); the receive-side counterpart of the combinational encrypt path.

---
 rtl/des_decrypt_iter.sv | 197 +++++++++++++++++++
 tb/tb_des_decrypt_iter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core. Runs ROUNDS_PER_CYCLE Feistel rounds per clock and derives
// round keys K16..K1 on the fly by rotating C/D right, so no round-key table is stored.
module des_decrypt_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_text,
    input  logic [63:0] cipher_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_text,
    output logic        busy
);

    // Permutation tables use DES bit numbering: entry n names input bit n, bit 1 = MSB.
    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    // S1..S8, each 4 rows of 16 columns, flattened as box*64 + row*16 + col.
    localparam logic [3:0] SBOX_T [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] ex;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) ex[47-i] = r[32-E_T[i]];
        ex = ex ^ k;
        s  = '0;
        for (int b = 0; b < 8; b++) begin
            six = ex[47-6*b -: 6];
            s[31-4*b -: 4] = SBOX_T[b*64 + 32'({six[5], six[0]}) * 16 + 32'(six[4:1])];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    // Right-rotation before decrypt round j; j=1 takes K16 straight from PC-1.
    function automatic logic [1:0] rot_amt(input logic [4:0] j);
        if (j == 5'd1) return 2'd0;
        if (j == 5'd2 || j == 5'd9 || j == 5'd16) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] plain_reg;
    logic [31:0] l_fin, r_fin;
    logic [27:0] c_fin, d_fin;
    logic        last_step;

    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
        logic [31:0] l_in, r_in, l_out, r_out;
        logic [27:0] c_in, d_in, c_out, d_out;
        logic [4:0]  j;
        if (gi == 0) begin : g_head
            assign l_in = l_reg;
            assign r_in = r_reg;
            assign c_in = c_reg;
            assign d_in = d_reg;
        end else begin : g_link
            assign l_in = g_round[gi-1].l_out;
            assign r_in = g_round[gi-1].r_out;
            assign c_in = g_round[gi-1].c_out;
            assign d_in = g_round[gi-1].d_out;
        end
        assign j     = cnt_reg + 5'(gi + 1);
        assign c_out = rotr28(c_in, rot_amt(j));
        assign d_out = rotr28(d_in, rot_amt(j));
        assign l_out = r_in;
        assign r_out = l_in ^ feistel(r_in, pc2_perm({c_out, d_out}));
    end

    assign l_fin     = g_round[ROUNDS_PER_CYCLE-1].l_out;
    assign r_fin     = g_round[ROUNDS_PER_CYCLE-1].r_out;
    assign c_fin     = g_round[ROUNDS_PER_CYCLE-1].c_out;
    assign d_fin     = g_round[ROUNDS_PER_CYCLE-1].d_out;
    assign last_step = (cnt_reg == 5'(16 - ROUNDS_PER_CYCLE));

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            cnt_reg   <= '0;
            plain_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    {l_reg, r_reg} <= ip_perm(cipher_text);
                    {c_reg, d_reg} <= pc1_perm(cipher_key);
                    cnt_reg        <= '0;
                end
                RUN: begin
                    l_reg   <= l_fin;
                    r_reg   <= r_fin;
                    c_reg   <= c_fin;
                    d_reg   <= d_fin;
                    cnt_reg <= cnt_reg + 5'(ROUNDS_PER_CYCLE);
                    if (last_step) plain_reg <= fp_perm({r_fin, l_fin});
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign plain_text = plain_reg;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: directed known-answer, handshake and reset steps, then random
// blocks encrypted by a behavioural DES model and decrypted by instances with 1, 2 and 4 rounds/clock.
module tb_des_decrypt_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid    [3];
    logic        in_ready    [3];
    logic [63:0] cipher_text [3];
    logic [63:0] cipher_key  [3];
    logic        out_valid   [3];
    logic        out_ready   [3];
    logic [63:0] plain_text  [3];
    logic        busy        [3];
    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        des_decrypt_iter #(.ROUNDS_PER_CYCLE(1 << gi)) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
            .cipher_text(cipher_text[gi]), .cipher_key(cipher_key[gi]),
            .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
            .plain_text(plain_text[gi]), .busy(busy[gi])
        );
    end

    // Reference DES tables (FIPS 46-3 numbering, bit 1 = MSB).
    int ip_t[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int e_t[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int shifts[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sbox_t [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

    // Selects bits of an in_w-wide value (right-aligned in x) in table order, right-aligned result.
    function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int tab[$]);
        logic [63:0] y = '0;
        foreach (tab[i]) y = (y << 1) | 64'(x[in_w - tab[i]]);
        return y;
    endfunction

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s = '0;
        logic [5:0]  six;
        x = 48'(permute({32'h0, r}, 32, e_t)) ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s = (s << 4) | 32'(sbox_t[b][{six[5], six[0]}][six[4:1]]);
        end
        return 32'(permute({32'h0, s}, 32, p_t));
    endfunction

    // Forward encryption with the textbook left-rotating key schedule K1..K16.
    function automatic logic [63:0] des_encrypt(input logic [63:0] key, input logic [63:0] pt);
        logic [55:0] cd;
        logic [63:0] lr;
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        logic [47:0] k;
        cd = 56'(permute(key, 64, pc1_t));
        c  = cd[55:28];
        d  = cd[27:0];
        lr = permute(pt, 64, ip_t);
        l  = lr[63:32];
        r  = lr[31:0];
        for (int j = 0; j < 16; j++) begin
            repeat (shifts[j]) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            k = 48'(permute({8'h0, c, d}, 56, pc2_t));
            t = r;
            r = l ^ f_model(r, k);
            l = t;
        end
        return permute({r, l}, 64, fp_t);
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int d, input logic [63:0] key, input logic [63:0] ct);
        cipher_key[d]  = key;
        cipher_text[d] = ct;
        in_valid[d]    = 1'b1;
        tick();
        in_valid[d]    = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid, bounded at 40.
    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out(input int d);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
    endtask

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;

    initial begin
        logic [63:0] key, pt, ct;
        int lat;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; cipher_text[i] = '0; cipher_key[i] = '0;
        end
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_plain_text", plain_text[0], 64'd0);
        rst = 1'b0;
        tick();

        accept(0, KEY1, CT1);
        check("t1_busy", 64'(busy[0]), 64'd1);
        wait_valid(0, lat);
        check("t1_latency", 64'(lat), 64'd16);
        check("t1_pt", plain_text[0], PT1);
        $display("txn t1 key=%h ct=%h pt=%h lat=%0d", KEY1, CT1, plain_text[0], lat);
        release_out(0);

        accept(0, KEY2, 64'h0);
        wait_valid(0, lat);
        check("t2_pt", plain_text[0], PT2);
        $display("txn t2 key=%h ct=%h pt=%h lat=%0d", KEY2, 64'h0, plain_text[0], lat);
        release_out(0);
        accept(0, KEY2 ^ 64'h0101010101010101, 64'h0);
        wait_valid(0, lat);
        check("t2_parity_pt", plain_text[0], PT2);
        $display("txn t2p key=%h ct=%h pt=%h lat=%0d", KEY2 ^ 64'h0101010101010101, 64'h0, plain_text[0], lat);
        release_out(0);

        accept(0, KEY1, CT1);
        wait_valid(0, lat);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_pt", plain_text[0], PT1);
            check("t3_hold_out_valid", 64'(out_valid[0]), 64'd1);
            check("t3_hold_in_ready", 64'(in_ready[0]), 64'd0);
            tick();
        end
        in_valid[0] = 1'b1;
        cipher_text[0] = 64'hDEADBEEFCAFEF00D;
        release_out(0);
        in_valid[0] = 1'b0;
        check("t3_release_out_valid", 64'(out_valid[0]), 64'd0);
        check("t3_release_in_ready", 64'(in_ready[0]), 64'd1);
        $display("txn t3 key=%h ct=%h pt=%h lat=%0d", KEY1, CT1, PT1, lat);

        accept(0, KEY1, CT1);
        for (int i = 0; i < 10; i++) begin
            in_valid[0]    = i[0];
            cipher_text[0] = {$urandom, $urandom};
            cipher_key[0]  = {$urandom, $urandom};
            tick();
        end
        in_valid[0] = 1'b0;
        wait_valid(0, lat);
        check("t4_latency_rest", 64'(lat), 64'd6);
        check("t4_pt", plain_text[0], PT1);
        $display("txn t4 key=%h ct=%h pt=%h lat=%0d", KEY1, CT1, plain_text[0], lat + 10);
        release_out(0);

        accept(0, KEY1, CT1);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_out_valid", 64'(out_valid[0]), 64'd0);
        check("t5_in_ready", 64'(in_ready[0]), 64'd1);
        check("t5_busy", 64'(busy[0]), 64'd0);
        check("t5_plain_text", plain_text[0], 64'd0);
        accept(0, KEY2, 64'h0);
        wait_valid(0, lat);
        check("t5_after_pt", plain_text[0], PT2);
        check("t5_after_latency", 64'(lat), 64'd16);
        $display("txn t5 key=%h ct=%h pt=%h lat=%0d", KEY2, 64'h0, plain_text[0], lat);
        release_out(0);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 1000; n++) begin
                key = {$urandom, $urandom};
                pt  = {$urandom, $urandom};
                ct  = des_encrypt(key, pt);
                accept(d, key, ct);
                wait_valid(d, lat);
                check($sformatf("rand_r%0d_latency", 1 << d), 64'(lat), 64'(16 >> d));
                check($sformatf("rand_r%0d_pt", 1 << d), plain_text[d], pt);
                $display("txn r%0d n=%0d key=%h ct=%h pt=%h lat=%0d", 1 << d, n, key, ct, plain_text[d], lat);
                release_out(d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout after %0d checks", n_total);
        $fatal(1, "simulation did not finish");
    end

endmodule
